// File: rtl/smart_home_sensor_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : smart_home_sensor_conditioner_if
// Description : Bundle of the raw sensor lines entering the conditioner and
//               the conditioned levels it hands to the home-state FSM.
//               master : drives raw_* lines, observes conditioned outputs
//               slave  : the conditioner itself
// Ports       : raw_fd/raw_rd/raw_w/raw_fa (raw binary sensors, async)
//               raw_temp[6:0] (ADC code, already synchronous)
//               SFD/SRD/SW/SFA (clean levels), ST[6:0] (averaged temperature)
//               temp_valid (first average done), sample_tick (debug pulse)
// Revision    : 1.0 - initial release
// ============================================================================
interface smart_home_sensor_conditioner_if;
    logic       raw_fd;
    logic       raw_rd;
    logic       raw_w;
    logic       raw_fa;
    logic [6:0] raw_temp;
    logic       SFD;
    logic       SRD;
    logic       SW;
    logic       SFA;
    logic [6:0] ST;
    logic       temp_valid;
    logic       sample_tick;

    modport master (
        output raw_fd, raw_rd, raw_w, raw_fa, raw_temp,
        input  SFD, SRD, SW, SFA, ST, temp_valid, sample_tick
    );

    modport slave (
        input  raw_fd, raw_rd, raw_w, raw_fa, raw_temp,
        output SFD, SRD, SW, SFA, ST, temp_valid, sample_tick
    );
endinterface
`default_nettype wire

// File: rtl/smart_home_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : smart_home_sensor_conditioner
// Description : Front end of the smart-home controller. Synchronizes and
//               debounces the door, window and fire-alarm lines and box-car
//               averages the temperature code before it reaches the FSM.
// Ports       : clk_i  - system clock, rising edge
//               rst_i  - synchronous active-high reset
//               bus    - slave side of smart_home_sensor_conditioner_if
// Revision    : 1.0 - initial release
// ============================================================================
module smart_home_sensor_conditioner #(
    parameter int         DEBOUNCE_CYCLES    = 4,
    parameter int         FA_DEBOUNCE_CYCLES = 2,
    parameter int         SAMPLE_DIV         = 8,
    parameter int         TEMP_AVG_LOG2      = 2,
    parameter logic [6:0] TEMP_RESET         = 7'd25
) (
    input  wire logic                     clk_i,
    input  wire logic                     rst_i,
    smart_home_sensor_conditioner_if.slave bus
);

    localparam int c_acc_w = 7 + TEMP_AVG_LOG2;
    // Sample counter needs at least one bit even when no averaging is done.
    localparam int c_n_w   = (TEMP_AVG_LOG2 == 0) ? 1 : TEMP_AVG_LOG2;
    localparam logic [c_n_w-1:0] c_n_last   = c_n_w'((1 << TEMP_AVG_LOG2) - 1);
    localparam logic [15:0]      c_div_last = 16'(SAMPLE_DIV - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizers, channel order {fa, w, rd, fd}
    // ------------------------------------------------------------------
    logic [3:0] w_raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] w_clean;

    assign w_raw = {bus.raw_fa, bus.raw_w, bus.raw_rd, bus.raw_fd};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= w_raw;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce: output follows the synchronized level only
    // after it has disagreed for N consecutive clocks. Any agreeing clock
    // restarts the count.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        localparam logic [7:0] c_last = (gi == 3) ? 8'(FA_DEBOUNCE_CYCLES - 1)
                                                  : 8'(DEBOUNCE_CYCLES - 1);
        logic [7:0] cnt_q;
        logic [7:0] cnt_d;
        logic       out_q;
        logic       out_d;

        always_comb begin
            cnt_d = cnt_q;
            out_d = out_q;
            if (sync2_q[gi] == out_q) begin
                cnt_d = '0;
            end else if (cnt_q == c_last) begin
                out_d = sync2_q[gi];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
                out_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                out_q <= out_d;
            end
        end

        assign w_clean[gi] = out_q;
    end

    // ------------------------------------------------------------------
    // Sample divider; the tick is decoded from the terminal count so the
    // first one lands SAMPLE_DIV clocks after reset is released.
    // ------------------------------------------------------------------
    logic [15:0] div_q;
    logic [15:0] div_d;
    logic        w_tick;

    assign w_tick = (div_q == c_div_last) && !rst_i;

    always_comb begin
        div_d = div_q + 16'd1;
        if (div_q == c_div_last) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Box-car averager. The accumulator is wide enough for 2^L full-scale
    // samples, so the final sum never wraps.
    // ------------------------------------------------------------------
    logic [c_acc_w-1:0] acc_q;
    logic [c_acc_w-1:0] acc_d;
    logic [c_acc_w-1:0] w_sum;
    logic [c_n_w-1:0]   n_q;
    logic [c_n_w-1:0]   n_d;
    logic [6:0]         st_q;
    logic [6:0]         st_d;
    logic               valid_q;
    logic               valid_d;

    assign w_sum = acc_q + c_acc_w'(bus.raw_temp);

    always_comb begin
        acc_d   = acc_q;
        n_d     = n_q;
        st_d    = st_q;
        valid_d = valid_q;
        if (w_tick) begin
            if (n_q == c_n_last) begin
                st_d    = 7'(w_sum >> TEMP_AVG_LOG2);
                acc_d   = '0;
                n_d     = '0;
                valid_d = 1'b1;
            end else begin
                acc_d = w_sum;
                n_d   = n_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            n_q     <= '0;
            st_q    <= TEMP_RESET;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            n_q     <= n_d;
            st_q    <= st_d;
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.SFD         = w_clean[0];
    assign bus.SRD         = w_clean[1];
    assign bus.SW          = w_clean[2];
    assign bus.SFA         = w_clean[3];
    assign bus.ST          = st_q;
    assign bus.temp_valid  = valid_q;
    assign bus.sample_tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_smart_home_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_smart_home_sensor_conditioner
// Description : Directed self-checking bench for the sensor conditioner with
//               DEBOUNCE_CYCLES=4, FA_DEBOUNCE_CYCLES=2, SAMPLE_DIV=8,
//               TEMP_AVG_LOG2=2, TEMP_RESET=25. Inputs change and outputs are
//               sampled 1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smart_home_sensor_conditioner;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;   // edges since reset release
    logic hi_seen;

    always #5 clk = ~clk;

    smart_home_sensor_conditioner_if bus ();

    smart_home_sensor_conditioner #(
        .DEBOUNCE_CYCLES    (4),
        .FA_DEBOUNCE_CYCLES (2),
        .SAMPLE_DIV         (8),
        .TEMP_AVG_LOG2      (2),
        .TEMP_RESET         (7'd25)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- 1: reset and first average ----------------
        rst          = 1'b1;
        bus.raw_fd   = 1'b0;
        bus.raw_rd   = 1'b0;
        bus.raw_w    = 1'b0;
        bus.raw_fa   = 1'b0;
        bus.raw_temp = 7'd40;
        repeat (3) step();
        check("rst_SFD", 32'(bus.SFD), 0);
        check("rst_SRD", 32'(bus.SRD), 0);
        check("rst_SW", 32'(bus.SW), 0);
        check("rst_SFA", 32'(bus.SFA), 0);
        check("rst_ST", 32'(bus.ST), 25);
        check("rst_valid", 32'(bus.temp_valid), 0);
        check("rst_tick", 32'(bus.sample_tick), 0);

        rst = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 6)  check("tick_before", 32'(bus.sample_tick), 0);
            if (i == 7)  check("tick_first", 32'(bus.sample_tick), 1);
            if (i == 8)  check("tick_after", 32'(bus.sample_tick), 0);
            if (i == 31) begin
                check("st_hold_25", 32'(bus.ST), 25);
                check("valid_early", 32'(bus.temp_valid), 0);
            end
            if (i == 32) begin
                check("st_first_avg", 32'(bus.ST), 40);
                check("valid_first", 32'(bus.temp_valid), 1);
            end
        end

        // ---------------- 2: front door and fire alarm latency -------
        bus.raw_fd = 1'b1;
        bus.raw_fa = 1'b1;
        repeat (3) step();
        check("sfa_edge3", 32'(bus.SFA), 0);
        step();
        check("sfa_edge4", 32'(bus.SFA), 1);
        check("sfd_edge4", 32'(bus.SFD), 0);
        step();
        check("sfd_edge5", 32'(bus.SFD), 0);
        step();
        check("sfd_edge6", 32'(bus.SFD), 1);
        check("srd_quiet", 32'(bus.SRD), 0);
        check("sw_quiet", 32'(bus.SW), 0);

        // ---------------- 3: window glitches then hold --------------
        for (int p = 0; p < 5; p++) begin
            bus.raw_w = 1'b1;
            repeat (3) step();
            bus.raw_w = 1'b0;
            repeat (3) step();
            check("sw_glitch", 32'(bus.SW), 0);
        end
        bus.raw_w = 1'b1;
        repeat (5) step();
        check("sw_hold5", 32'(bus.SW), 0);
        step();
        check("sw_hold6", 32'(bus.SW), 1);

        // ---------------- 4: averaging and truncation ---------------
        while ((cyc % 32) != 0) step();
        bus.raw_temp = 7'd10;
        repeat (8) step();
        bus.raw_temp = 7'd11;
        repeat (8) step();
        bus.raw_temp = 7'd12;
        repeat (8) step();
        bus.raw_temp = 7'd14;
        repeat (7) step();
        check("st_hold_40", 32'(bus.ST), 40);
        step();
        check("st_avg_47", 32'(bus.ST), 11);
        bus.raw_temp = 7'd127;
        repeat (31) step();
        check("st_hold_11", 32'(bus.ST), 11);
        step();
        check("st_full_scale", 32'(bus.ST), 127);
        check("valid_stays", 32'(bus.temp_valid), 1);

        // ---------------- 5: reset mid-window -----------------------
        bus.raw_temp = 7'd100;
        repeat (19) step();          // two samples of 100 accumulated
        check("sfd_pre_rst", 32'(bus.SFD), 1);
        rst = 1'b1;
        step();
        check("mid_rst_SFD", 32'(bus.SFD), 0);
        check("mid_rst_SFA", 32'(bus.SFA), 0);
        check("mid_rst_SW", 32'(bus.SW), 0);
        check("mid_rst_ST", 32'(bus.ST), 25);
        check("mid_rst_valid", 32'(bus.temp_valid), 0);
        rst          = 1'b0;
        cyc          = 0;
        bus.raw_temp = 7'd20;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 5)  check("sfd_relearn5", 32'(bus.SFD), 0);
            if (i == 6)  check("sfd_relearn6", 32'(bus.SFD), 1);
            if (i == 31) check("st_restart_hold", 32'(bus.ST), 25);
            if (i == 32) begin
                check("st_restart_avg", 32'(bus.ST), 20);
                check("valid_restart", 32'(bus.temp_valid), 1);
            end
        end

        // ---------------- 6: rear door chatter ----------------------
        hi_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.raw_rd = (i % 2 == 0);
            step();
            if (bus.SRD) hi_seen = 1'b1;
        end
        check("srd_chatter", 32'(hi_seen), 0);
        bus.raw_rd = 1'b1;
        repeat (5) step();
        check("srd_settle5", 32'(bus.SRD), 0);
        step();
        check("srd_settle6", 32'(bus.SRD), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smart_home_sensor_conditioner.md
Name: smart_home_sensor_conditioner

Overview:
- Front end of the smart-home controller; sits directly upstream of the home-state FSM.
- Takes raw, bouncy door, window and fire sensor lines, plus the raw 7-bit temperature code.
- Drives the FSM's SFD, SRD, SW, SFA and ST inputs with clean, synchronized, debounced levels and a box-car-averaged temperature.
- Also flags when the temperature value becomes valid after reset.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clocks a synchronized binary sensor must differ from its output before the output flips (range 1..255).
- FA_DEBOUNCE_CYCLES, 2: same rule, applied to the fire-alarm channel only (range 1..255).
- SAMPLE_DIV, 8: clocks per temperature sample tick (range 2..65535).
- TEMP_AVG_LOG2, 2: log2 of the number of samples averaged per temperature update (range 0..4).
- TEMP_RESET, 7'd25: value driven on ST from reset until the first average completes.

Ports:
- Clk, input, 1: single system clock, rising edge.
- Rst, input, 1: synchronous, active-high reset.
- raw_fd, input, 1: raw front-door sensor, asynchronous.
- raw_rd, input, 1: raw rear-door sensor, asynchronous.
- raw_w, input, 1: raw window sensor, asynchronous.
- raw_fa, input, 1: raw fire-alarm sensor, asynchronous.
- raw_temp, input, 7: temperature code from the ADC register, already synchronous to Clk.
- SFD, output, 1: conditioned front-door level.
- SRD, output, 1: conditioned rear-door level.
- SW, output, 1: conditioned window level.
- SFA, output, 1: conditioned fire-alarm level.
- ST, output, 7: averaged temperature.
- temp_valid, output, 1: high once the first averaging window has completed.
- sample_tick, output, 1: one-clock pulse on each temperature sample, for debug and verification.

Behaviour:
Reset:
- Rst is sampled on the Clk edge and overrides everything.
- SFD=SRD=SW=SFA=0, ST=TEMP_RESET, temp_valid=0, sample_tick=0.
- All synchronizer flops, debounce counters, divider, accumulator and sample count are cleared to 0.

Synchronizers:
- Each raw_* binary line passes through a 2-flop synchronizer (s1 then s2). raw_temp is not synchronized.

Debounce, per binary channel, independent:
- Counter cnt, 8 bits.
- Each clock where s2 == output: cnt <= 0.
- Each clock where s2 != output:
  - if cnt == N-1: output <= s2 and cnt <= 0;
  - otherwise cnt <= cnt+1.
- N = DEBOUNCE_CYCLES for fd/rd/w and FA_DEBOUNCE_CYCLES for fa.
- Latency: raw held stable from before edge k gives the output flip on edge k+1+N. That is N+2 edges, so 6 with N=4 and 4 for fire.
- A glitch shorter than N synchronized clocks produces no output change. One equal cycle restarts the count, even at cnt == N-1.

Sample divider:
- div counts 0..SAMPLE_DIV-1.
- On div == SAMPLE_DIV-1: div <= 0 and sample_tick = 1 for that cycle.
- The first tick occurs SAMPLE_DIV clocks after Rst deasserts.

Temperature averaging:
- Accumulator acc is 7+TEMP_AVG_LOG2 bits and cannot overflow. Sample counter n runs 0..2^TEMP_AVG_LOG2-1.
- On a tick, raw_temp is captured that same cycle.
  - If n < 2^TEMP_AVG_LOG2-1: acc <= acc+raw_temp and n <= n+1.
  - Else (last sample): ST <= (acc+raw_temp) >> TEMP_AVG_LOG2 (truncating, no rounding), acc <= 0, n <= 0, temp_valid <= 1.
- ST changes only on window-final ticks and holds its value between them.
- temp_valid stays high until the next Rst.
- TEMP_AVG_LOG2=0 means ST follows raw_temp sampled on each tick.

Concurrency:
- All channels and the temperature path run concurrently with no interaction.
- A binary sensor flip and a temperature update may land on the same edge.
- Rst mid-window discards the partial sum, and ST returns to TEMP_RESET.

Test Plan:
1. Rst high 3 clocks, then low; raw_* = 0, raw_temp = 40 -> SFD..SFA = 0 and ST = 25 until clock 32 after reset; then ST = 40 and temp_valid = 1 (SAMPLE_DIV=8, 4 samples).
2. raw_fd 0->1 held -> SFD rises on the 6th edge after the change. raw_fa 0->1 -> SFA rises on the 4th edge. SRD/SW stay 0.
3. raw_w pulses high for 3 clocks, then low, repeated 5 times -> SW stays 0. Then raw_w held high for 6 clocks -> SW = 1.
4. raw_temp samples 10, 11, 12, 14 on four consecutive ticks -> ST = 11 (47>>2) after the fourth tick. Next window 127 x4 -> ST = 127, with no overflow.
5. Rst asserted after 2 ticks of a window while SFD = 1 -> next edge SFD = 0, ST = 25, temp_valid = 0. The following window restarts from n = 0.
6. raw_rd toggles at the clock rate for 100 clocks, then settles to 1 -> SRD changes only after settling, 6 edges later.
